// File: rtl/soc_ahb4_ext_responder_pkg.sv
// Shared AHB4-Lite encodings and responder state type.
// Included by the responder top, its lane decoder and the interface users.
package soc_ahb4_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_ERR1,
    S_ERR2
  } resp_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/soc_ahb4_ext_responder_if.sv
// AHB4-Lite bus bundle between the external master port and the responder.
// Signal suffixes follow the responder's point of view (_i into it, _o out of it).
interface soc_ahb4_ext_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel_i;
  logic [ADDR_WIDTH-1:0] haddr_i;
  logic [DATA_WIDTH-1:0] hwdata_i;
  logic                  hwrite_i;
  logic [2:0]            hsize_i;
  logic [2:0]            hburst_i;
  logic [3:0]            hprot_i;
  logic [1:0]            htrans_i;
  logic                  hmastlock_i;
  logic [DATA_WIDTH-1:0] hrdata_o;
  logic                  hready_o;
  logic                  hresp_o;

  modport slave (
    input  hsel_i, haddr_i, hwdata_i, hwrite_i, hsize_i, hburst_i, hprot_i,
           htrans_i, hmastlock_i,
    output hrdata_o, hready_o, hresp_o
  );

  modport master (
    output hsel_i, haddr_i, hwdata_i, hwrite_i, hsize_i, hburst_i, hprot_i,
           htrans_i, hmastlock_i,
    input  hrdata_o, hready_o, hresp_o
  );
endinterface

// File: rtl/soc_ahb4_ext_responder_lane_decode.sv
// Combinational (hsize, addr[1:0]) -> little-endian byte strobe plus misaligned flag.
// Sizes above a word are reported as misaligned so they fold into the error check.
module soc_ahb4_lane_decode
  import soc_ahb4_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] strb_o,
  output logic       misaligned_o
);

  always_comb begin
    strb_o       = 4'b0000;
    misaligned_o = 1'b0;
    case (hsize_i)
      HSIZE_BYTE: strb_o = 4'b0001 << addr_lo_i;
      HSIZE_HALF: begin
        strb_o       = 4'b0011 << addr_lo_i;
        misaligned_o = addr_lo_i[0];
      end
      HSIZE_WORD: begin
        strb_o       = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/soc_ahb4_ext_responder.sv
// AHB4-Lite memory-window responder: 1+WAIT_STATES cycle OKAY data phase, 2-cycle ERROR.
// Optional saturating access counters when SOC_AHB4_RESPONDER_STATS_EN is defined.
module soc_ahb4_ext_responder
  import soc_ahb4_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_WORDS   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  soc_ahb4_ext_responder_if.slave    ahb
`ifdef SOC_AHB4_RESPONDER_STATS_EN
  ,
  output logic [31:0]                stat_reads_o,
  output logic [31:0]                stat_writes_o,
  output logic [31:0]                stat_errors_o
`endif
);

  localparam int         IDX_W     = $clog2(MEM_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  resp_state_t           state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [1:0]            lo_q, lo_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_window;
  logic [3:0]            ap_strb;
  logic                  ap_misaligned;
  logic [3:0]            wr_strb;
  logic                  wr_misaligned;
  logic                  bad;
  logic                  hready;
  logic                  hresp;
  logic                  accept;
  logic                  take;
  logic                  final_cyc;
  logic                  commit_wr;
  logic                  unused_ok;

  soc_ahb4_lane_decode u_ap_decode (
    .hsize_i      (ahb.hsize_i),
    .addr_lo_i    (ahb.haddr_i[1:0]),
    .strb_o       (ap_strb),
    .misaligned_o (ap_misaligned)
  );

  soc_ahb4_lane_decode u_wr_decode (
    .hsize_i      (size_q),
    .addr_lo_i    (lo_q),
    .strb_o       (wr_strb),
    .misaligned_o (wr_misaligned)
  );

  // Subtraction cannot wrap once haddr >= BASE_ADDR, so the upper offset bits bound the window.
  assign offset    = ahb.haddr_i - BASE_ADDR;
  assign in_window = (ahb.haddr_i >= BASE_ADDR) && (offset[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign bad       = !in_window || ap_misaligned;

  assign final_cyc = (state_q == S_DATA) && (wait_q == 4'd0);
  assign commit_wr = final_cyc && write_q;

  always_comb begin
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    case (state_q)
      S_DATA:  hready = (wait_q == 4'd0);
      S_ERR1:  begin hready = 1'b0; hresp = HRESP_ERROR; end
      S_ERR2:  hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  assign accept = hready && ahb.hsel_i && ahb.htrans_i[1];

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    write_d = write_q;
    size_d  = size_q;
    take    = 1'b0;
    case (state_q)
      S_IDLE, S_ERR2: begin
        take    = accept;
        state_d = S_IDLE;
      end
      S_DATA: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          take    = accept;
          state_d = S_IDLE;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (take) begin
      if (bad) begin
        state_d = S_ERR1;
      end else begin
        state_d = S_DATA;
        wait_d  = WAIT_LOAD;
        idx_d   = offset[IDX_W+1:2];
        lo_d    = ahb.haddr_i[1:0];
        write_d = ahb.hwrite_i;
        size_d  = ahb.hsize_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
      idx_q   <= '0;
      lo_q    <= 2'd0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  // Contents survive reset; reset only blocks an in-flight commit.
  always_ff @(posedge clk) begin
    if (!rst && commit_wr) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wr_strb[b]) mem_q[idx_q][8*b +: 8] <= ahb.hwdata_i[8*b +: 8];
      end
    end
  end

  assign ahb.hready_o = hready;
  assign ahb.hresp_o  = hresp;
  assign ahb.hrdata_o = (final_cyc && !write_q) ? mem_q[idx_q] : '0;

  assign unused_ok = ^{ahb.hburst_i, ahb.hprot_i, ahb.hmastlock_i, ahb.htrans_i[0],
                       offset[1:0], ap_strb, wr_misaligned};

`ifdef SOC_AHB4_RESPONDER_STATS_EN
  logic [31:0] reads_q, reads_d;
  logic [31:0] writes_q, writes_d;
  logic [31:0] errors_q, errors_d;

  always_comb begin
    reads_d  = sat_inc(reads_q, final_cyc && !write_q);
    writes_d = sat_inc(writes_q, commit_wr);
    errors_d = sat_inc(errors_q, state_d == S_ERR1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reads_q  <= 32'd0;
      writes_q <= 32'd0;
      errors_q <= 32'd0;
    end else begin
      reads_q  <= reads_d;
      writes_q <= writes_d;
      errors_q <= errors_d;
    end
  end

  assign stat_reads_o  = reads_q;
  assign stat_writes_o = writes_q;
  assign stat_errors_o = errors_q;
`endif

endmodule

// File: tb/tb_soc_ahb4_ext_responder.sv
// Directed bench for soc_ahb4_ext_responder with WAIT_STATES 0, 3 and 5 instances
// sharing one stimulus set; dut_sel routes hsel and selects which outputs are observed.
module tb_soc_ahb4_ext_responder;
  import soc_ahb4_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_v;
  logic [1:0]  dut_sel;
  logic        hsel;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;

  int errors;
  int checks;

  soc_ahb4_ext_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  soc_ahb4_ext_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  soc_ahb4_ext_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

  assign bus0.hsel_i = hsel && (dut_sel == 2'd0);
  assign bus1.hsel_i = hsel && (dut_sel == 2'd1);
  assign bus2.hsel_i = hsel && (dut_sel == 2'd2);
  assign bus0.haddr_i = haddr;   assign bus1.haddr_i = haddr;   assign bus2.haddr_i = haddr;
  assign bus0.hwdata_i = hwdata; assign bus1.hwdata_i = hwdata; assign bus2.hwdata_i = hwdata;
  assign bus0.hwrite_i = hwrite; assign bus1.hwrite_i = hwrite; assign bus2.hwrite_i = hwrite;
  assign bus0.hsize_i = hsize;   assign bus1.hsize_i = hsize;   assign bus2.hsize_i = hsize;
  assign bus0.htrans_i = htrans; assign bus1.htrans_i = htrans; assign bus2.htrans_i = htrans;
  assign bus0.hburst_i = 3'd0;   assign bus1.hburst_i = 3'd0;   assign bus2.hburst_i = 3'd0;
  assign bus0.hprot_i = 4'd3;    assign bus1.hprot_i = 4'd3;    assign bus2.hprot_i = 4'd3;
  assign bus0.hmastlock_i = 1'b0; assign bus1.hmastlock_i = 1'b0; assign bus2.hmastlock_i = 1'b0;

`ifdef SOC_AHB4_RESPONDER_STATS_EN
  logic [31:0] st_rd [3];
  logic [31:0] st_wr [3];
  logic [31:0] st_er [3];
`endif

  soc_ahb4_ext_responder #(.WAIT_STATES(0)) dut0 (
    .clk (clk), .rst (rst_v[0]), .ahb (bus0.slave)
`ifdef SOC_AHB4_RESPONDER_STATS_EN
    , .stat_reads_o (st_rd[0]), .stat_writes_o (st_wr[0]), .stat_errors_o (st_er[0])
`endif
  );

  soc_ahb4_ext_responder #(.WAIT_STATES(3)) dut1 (
    .clk (clk), .rst (rst_v[1]), .ahb (bus1.slave)
`ifdef SOC_AHB4_RESPONDER_STATS_EN
    , .stat_reads_o (st_rd[1]), .stat_writes_o (st_wr[1]), .stat_errors_o (st_er[1])
`endif
  );

  soc_ahb4_ext_responder #(.WAIT_STATES(5)) dut2 (
    .clk (clk), .rst (rst_v[2]), .ahb (bus2.slave)
`ifdef SOC_AHB4_RESPONDER_STATS_EN
    , .stat_reads_o (st_rd[2]), .stat_writes_o (st_wr[2]), .stat_errors_o (st_er[2])
`endif
  );

  logic        obs_rdy;
  logic        obs_resp;
  logic [31:0] obs_rdata;

  always_comb begin
    obs_rdy   = bus0.hready_o;
    obs_resp  = bus0.hresp_o;
    obs_rdata = bus0.hrdata_o;
    case (dut_sel)
      2'd1: begin obs_rdy = bus1.hready_o; obs_resp = bus1.hresp_o; obs_rdata = bus1.hrdata_o; end
      2'd2: begin obs_rdy = bus2.hready_o; obs_resp = bus2.hresp_o; obs_rdata = bus2.hrdata_o; end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic sel, input logic [1:0] tr, input logic wr,
                     input logic [2:0] sz, input logic [31:0] a);
    hsel   = sel;
    htrans = tr;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
  endtask

  task automatic idle();
    drv(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic rdy, input logic resp, input logic [31:0] rdata);
    #1;
    chk({tag, ".hready"}, {31'd0, obs_rdy}, {31'd0, rdy});
    chk({tag, ".hresp"}, {31'd0, obs_resp}, {31'd0, resp});
    chk({tag, ".hrdata"}, obs_rdata, rdata);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst_v   = 3'b111;
    dut_sel = 2'd0;
    hwdata  = 32'h0;
    idle();
    repeat (2) tick();
    rst_v = 3'b000;
    for (int s = 0; s < 3; s++) begin
      dut_sel = 2'(s);
      chk3("reset", 1'b1, 1'b0, 32'h0);
    end

    // Zero-wait write then back-to-back read
    dut_sel = 2'd0;
    drv(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h8000_0010);
    chk3("t1.wr_addr", 1'b1, 1'b0, 32'h0);
    tick(); hwdata = 32'hDEAD_BEEF; drv(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h8000_0010);
    chk3("t1.wr_data", 1'b1, 1'b0, 32'h0);
    tick(); idle(); hwdata = 32'h0;
    chk3("t1.rd_data", 1'b1, 1'b0, 32'hDEAD_BEEF);
    tick();
    chk3("t1.after", 1'b1, 1'b0, 32'h0);

    // Byte and halfword lanes merged into a word
    drv(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h8000_0020);
    tick(); hwdata = 32'h1122_3344; drv(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h8000_0021);
    tick(); hwdata = 32'hFFFF_A5FF; drv(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h8000_0022);
    tick(); hwdata = 32'h1234_FFFF; drv(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h8000_0020);
    chk3("t3.half_data", 1'b1, 1'b0, 32'h0);
    tick(); idle();
    chk3("t3.rd", 1'b1, 1'b0, 32'h1234_A544);
    tick();

    // Error responses: below window, misaligned half, oversize, just past window
    drv(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h7FFF_FFFC);
    tick(); idle(); chk3("t4.oow.err1", 1'b0, 1'b1, 32'h0);
    tick(); chk3("t4.oow.err2", 1'b1, 1'b1, 32'h0);
    tick(); chk3("t4.oow.idle", 1'b1, 1'b0, 32'h0);
    drv(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_HALF, 32'h8000_0001);
    tick(); idle(); chk3("t4.mis.err1", 1'b0, 1'b1, 32'h0);
    tick(); chk3("t4.mis.err2", 1'b1, 1'b1, 32'h0);
    tick(); chk3("t4.mis.idle", 1'b1, 1'b0, 32'h0);
    drv(1'b1, HTRANS_NONSEQ, 1'b0, 3'd3, 32'h8000_0000);
    tick(); idle(); chk3("t4.size3.err1", 1'b0, 1'b1, 32'h0);
    tick(); tick();
    drv(1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h8000_1000);
    tick(); idle(); chk3("t4.top.err1", 1'b0, 1'b1, 32'h0);
    tick(); tick();

    // Transfer accepted during the second error cycle
    drv(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h7FFF_FFFC);
    tick(); idle(); chk3("t5.err1", 1'b0, 1'b1, 32'h0);
    tick(); drv(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h8000_0030);
    chk3("t5.err2", 1'b1, 1'b1, 32'h0);
    tick(); hwdata = 32'hCAFE_F00D; drv(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h8000_0030);
    chk3("t5.wr_data", 1'b1, 1'b0, 32'h0);
    tick(); idle();
    chk3("t5.rd", 1'b1, 1'b0, 32'hCAFE_F00D);
    tick();

    // IDLE, BUSY and deselected NONSEQ must not touch memory
    drv(1'b1, HTRANS_IDLE, 1'b1, HSIZE_WORD, 32'h8000_0010);
    tick(); hwdata = 32'h0BAD_0BAD; drv(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h8000_0010);
    chk3("t6.idle", 1'b1, 1'b0, 32'h0);
    tick(); drv(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h8000_0010);
    chk3("t6.busy", 1'b1, 1'b0, 32'h0);
    tick(); drv(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h8000_0010);
    chk3("t6.nosel", 1'b1, 1'b0, 32'h0);
    tick(); idle();
    chk3("t6.rd", 1'b1, 1'b0, 32'hDEAD_BEEF);
    tick();
`ifdef SOC_AHB4_RESPONDER_STATS_EN
    chk("stats0.reads", st_rd[0], 32'd4);
    chk("stats0.writes", st_wr[0], 32'd5);
    chk("stats0.errors", st_er[0], 32'd5);
`endif

    // Three wait states
    dut_sel = 2'd1;
    drv(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h8000_0000);
    tick(); hwdata = 32'h5A5A_0001; idle();
    for (int i = 0; i < 3; i++) begin
      chk3("t2.wr_wait", 1'b0, 1'b0, 32'h0);
      tick();
    end
    drv(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h8000_0000);
    chk3("t2.wr_final", 1'b1, 1'b0, 32'h0);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      chk3("t2.rd_wait", 1'b0, 1'b0, 32'h0);
      tick();
    end
    chk3("t2.rd_final", 1'b1, 1'b0, 32'h5A5A_0001);
    tick();
    chk3("t2.after", 1'b1, 1'b0, 32'h0);

    // Five wait states, reset mid-write abandons the commit
    dut_sel = 2'd2;
    drv(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h8000_0040);
    tick(); hwdata = 32'h0101_0101; idle();
    repeat (5) tick();
    chk3("t7.first_final", 1'b1, 1'b0, 32'h0);
    tick();
    drv(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h8000_0040);
    tick(); hwdata = 32'h9999_9999; idle();
    tick(); tick();
    rst_v[2] = 1'b1;
    chk3("t7.wait3", 1'b0, 1'b0, 32'h0);
    tick(); rst_v[2] = 1'b0;
    chk3("t7.after_rst", 1'b1, 1'b0, 32'h0);
`ifdef SOC_AHB4_RESPONDER_STATS_EN
    chk("stats2.reads", st_rd[2], 32'd0);
    chk("stats2.writes", st_wr[2], 32'd0);
    chk("stats2.errors", st_er[2], 32'd0);
`endif
    drv(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h8000_0040);
    tick(); idle();
    for (int i = 0; i < 5; i++) begin
      chk3("t7.rd_wait", 1'b0, 1'b0, 32'h0);
      tick();
    end
    chk3("t7.rd_old", 1'b1, 1'b0, 32'h0101_0101);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
